// File: rtl/counter_161.sv
// rtl/counter_161.sv - presettable cascadable up/down counter with optional push-button step input
module counter_161 #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 15,
  parameter bit USE_STEP = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             LD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic             STEP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             step_pulse;
  logic             cnt_en;
  logic [WIDTH-1:0] q_next;

  // s1/s2 resynchronize the raw button; s3 delays s2 to turn each rising edge into a single pulse.
  // With USE_STEP=0 these flops drive nothing and are trimmed by synthesis.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= STEP;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step_pulse = USE_STEP ? (s2 & ~s3) : 1'b1;
  assign cnt_en     = LD_N & ENP & ENT & step_pulse;

  // Out-of-range values (loaded above MAX) fold back into 0..MAX in either direction.
  always_comb begin
    q_next = Q;
    if (!LD_N) begin
      q_next = D;
    end else if (cnt_en) begin
      if (UP) begin
        q_next = (Q >= MAX_V) ? '0 : Q + 1'b1;
      end else begin
        q_next = ((Q == '0) || (Q > MAX_V)) ? MAX_V : Q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      Q <= '0;
    end else begin
      Q <= q_next;
    end
  end

  assign RCO = ENT & (UP ? (Q == MAX_V) : (Q == '0));

endmodule
